// File: rtl/mips_divider.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient on Lo, remainder on Hi, one-cycle validOut pulse.
module mips_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic             busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUSY,
    DONE
  } state_t;

  state_t           state, state_n;
  logic             sign_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] q, rem, bmag;
  logic             neg_q, neg_r, b_zero;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             ge;

  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (validIn) state_n = LOAD;
      LOAD: state_n = BUSY;
      BUSY: if (count == CW'(WIDTH - 1)) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Trial subtract on WIDTH+1 bits so the shifted-out MSB is never lost.
  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    ge      = (shifted >= {1'b0, bmag});
    trial   = shifted[WIDTH-1:0] - bmag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      validOut <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
      count    <= '0;
      sign_r   <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      q        <= '0;
      rem      <= '0;
      bmag     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
    end else begin
      state    <= state_n;
      validOut <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (validIn) begin
            sign_r <= sign;
            a_r    <= SrcA;
            b_r    <= SrcB;
          end
        end
        LOAD: begin
          q      <= (sign_r && a_r[WIDTH-1]) ? -a_r : a_r;
          bmag   <= (sign_r && b_r[WIDTH-1]) ? -b_r : b_r;
          rem    <= '0;
          count  <= '0;
          neg_q  <= sign_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_r  <= sign_r & a_r[WIDTH-1];
          b_zero <= (b_r == '0);
        end
        BUSY: begin
          q     <= {q[WIDTH-2:0], ge};
          rem   <= ge ? trial : shifted[WIDTH-1:0];
          count <= count + 1'b1;
        end
        DONE: begin
          // Divide by zero yields all-ones quotient in both modes.
          Lo <= b_zero ? '1 : (neg_q ? -q : q);
          Hi <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_divider.sv
// Scoreboard bench for mips_divider: directed vectors,
// decoupled monitor checks Lo/Hi, latency and pulse width.
module tb_mips_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        validIn = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        validOut;
  logic        busy;
  logic [31:0] Hi, Lo;

  mips_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .validIn(validIn), .sign(sign),
    .SrcA(SrcA), .SrcB(SrcB),
    .validOut(validOut), .busy(busy),
    .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          total = 0;
  int          passed = 0;
  logic        vo_prev = 1'b0;
  logic [31:0] prev_lo = '0;
  logic [31:0] prev_hi = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && validOut) begin
      check("pulse_width", 32'(vo_prev), 32'd0);
      if (sb.size() == 0) begin
        check("stray_validOut", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("Lo", Lo, e.lo);
        check("Hi", Hi, e.hi);
        check("latency", 32'(cyc - e.issue), 32'd34);
      end
      done_cnt++;
    end
    vo_prev = validOut;
  end

  task automatic wait_done(input int n0);
    for (int i = 0; i < 60 && done_cnt == n0; i++) @(negedge clk);
    check("timeout", 32'(done_cnt != n0), 32'd1);
  endtask

  task automatic run_op(input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lo,
                        input logic [31:0] hi);
    int n0;
    @(negedge clk);
    sign = s; SrcA = a; SrcB = b; validIn = 1'b1;
    sb.push_back('{lo, hi, cyc + 1});
    n0 = done_cnt;
    @(negedge clk);
    validIn = 1'b0;
    SrcA = ~a; SrcB = ~b;
    repeat (5) @(negedge clk);
    check("busy_mid", 32'(busy), 32'd1);
    check("Lo_hold", Lo, prev_lo);
    check("Hi_hold", Hi, prev_hi);
    wait_done(n0);
    prev_lo = lo; prev_hi = hi;
    @(negedge clk);
  endtask

  initial begin
    int n0;
    int k;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(validOut), 32'd0);
    check("rst_Hi", Hi, 32'd0);
    check("rst_Lo", Lo, 32'd0);

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run_op(1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1);
    run_op(1'b1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    run_op(1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234);
    run_op(1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0);
    run_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
    run_op(1'b0, 32'd5, 32'd10, 32'd0, 32'd5);

    // Held validIn with churning operands, then one back-to-back op.
    @(negedge clk);
    sign = 1'b1; SrcA = 32'hFFFFFF9C; SrcB = 32'd7; validIn = 1'b1;
    sb.push_back('{32'hFFFFFFF2, 32'hFFFFFFFE, cyc + 1});
    n0 = done_cnt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (validOut) break;
      SrcA = $urandom; SrcB = $urandom; sign = ~sign;
    end
    check("hs_seen", 32'(validOut), 32'd1);
    sign = 1'b0; SrcA = 32'd100; SrcB = 32'd7;
    sb.push_back('{32'd14, 32'd2, cyc + 1});
    @(negedge clk);
    validIn = 1'b0;
    check("reissue_busy", 32'(busy), 32'd1);
    wait_done(n0 + 1);
    @(negedge clk);
    check("single_reissue", 32'(busy), 32'd0);
    prev_lo = 32'd14; prev_hi = 32'd2;

    // Reset at BUSY cycle 10 aborts the operation.
    @(negedge clk);
    sign = 1'b0; SrcA = 32'd100; SrcB = 32'd7; validIn = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    validIn = 1'b0;
    for (int i = 0; i < 40 && cyc < k + 11; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(validOut), 32'd0);
    check("abort_Hi", Hi, 32'd0);
    check("abort_Lo", Lo, 32'd0);
    prev_lo = '0; prev_hi = '0;
    repeat (40) @(negedge clk);
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
